// File: rtl/tm1637_display_ctrl.sv
// TM1637 frame sequencer: sends the 7-byte command/data frame to an external byte driver.
// Optional macro TM1637_HEX_DECODE_EN: digit nibbles are decoded to 7-segment patterns.
module tm1637_display_ctrl #(
  parameter int REFRESH_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        update,
  input  logic [31:0] digits,
  input  logic [2:0]  brightness,
  input  logic        display_on,
  output logic        ready,
  output logic        done,
  output logic        data_latch,
  output logic [7:0]  data_byte,
  output logic        data_stop_bit,
  input  logic        drv_busy
);

  // state | meaning: IDLE wait | LOAD present byte | LATCH strobe | WAIT_HI/WAIT_LO driver
  // handshake | NEXT advance index | DONE completion pulse, or restart if a request is pending
  typedef enum logic [2:0] {IDLE, LOAD, LATCH, WAIT_HI, WAIT_LO, NEXT, DONE} state_t;

  state_t      state;
  logic [2:0]  idx;
  logic        pending;
  logic [31:0] snap_digits;
  logic [2:0]  snap_bright;
  logic        snap_on;
  logic [31:0] refresh_cnt;
  logic        refresh_hit;

  function automatic logic [7:0] seg_byte(input logic [7:0] d);
`ifdef TM1637_HEX_DECODE_EN
    logic [6:0] seg;
    case (d[3:0])
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return {d[7], seg};
`else
    return d;
`endif
  endfunction

  // {byte, stop} for frame position i, built from the snapshot
  function automatic logic [8:0] frame_entry(input logic [2:0] i, input logic [31:0] d,
                                             input logic [2:0] br, input logic on);
    case (i)
      3'd0:    return {8'h40, 1'b1};
      3'd1:    return {8'hC0, 1'b0};
      3'd2:    return {seg_byte(d[7:0]), 1'b0};
      3'd3:    return {seg_byte(d[15:8]), 1'b0};
      3'd4:    return {seg_byte(d[23:16]), 1'b0};
      3'd5:    return {seg_byte(d[31:24]), 1'b1};
      default: return {4'b1000, on, br, 1'b1};
    endcase
  endfunction

  always_comb refresh_hit = (REFRESH_CYCLES > 0) && (refresh_cnt == 32'(REFRESH_CYCLES - 1));

  assign ready = (state == IDLE) && !pending;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      idx           <= 3'd0;
      pending       <= 1'b0;
      refresh_cnt   <= 32'd0;
      snap_digits   <= 32'd0;
      snap_bright   <= 3'd0;
      snap_on       <= 1'b0;
      data_latch    <= 1'b0;
      data_byte     <= 8'h00;
      data_stop_bit <= 1'b0;
      done          <= 1'b0;
    end else begin
      data_latch <= 1'b0;
      done       <= 1'b0;
      if (update && state != IDLE && state != DONE)
        pending <= 1'b1;
      case (state)
        IDLE: begin
          if (update || refresh_hit) begin
            snap_digits <= digits;
            snap_bright <= brightness;
            snap_on     <= display_on;
            idx         <= 3'd0;
            refresh_cnt <= 32'd0;
            state       <= LOAD;
          end else if (REFRESH_CYCLES > 0) begin
            refresh_cnt <= refresh_cnt + 32'd1;
          end
        end
        LOAD: begin
          {data_byte, data_stop_bit} <= frame_entry(idx, snap_digits, snap_bright, snap_on);
          if (!drv_busy) begin
            data_latch <= 1'b1;
            state      <= LATCH;
          end
        end
        LATCH:   state <= WAIT_HI;
        WAIT_HI: if (drv_busy) state <= WAIT_LO;
        WAIT_LO: if (!drv_busy) state <= NEXT;
        NEXT: begin
          if (idx == 3'd6) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx   <= idx + 3'd1;
            state <= LOAD;
          end
        end
        DONE: begin
          // a request landing in this very cycle counts as pending
          if (pending || update) begin
            snap_digits <= digits;
            snap_bright <= brightness;
            snap_on     <= display_on;
            pending     <= 1'b0;
            idx         <= 3'd0;
            refresh_cnt <= 32'd0;
            state       <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tm1637_display_ctrl.sv
// Bench for tm1637_display_ctrl: vector table plus scoreboard of expected {byte, stop} per latch.
module tb_tm1637_display_ctrl;
  localparam int REFRESH = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        update = 1'b0;
  logic [31:0] digits = 32'd0;
  logic [2:0]  brightness = 3'd0;
  logic        display_on = 1'b0;
  logic        drv_busy = 1'b0;
  logic        ready, done, data_latch, data_stop_bit;
  logic [7:0]  data_byte;

  always #5 clk = ~clk;

  tm1637_display_ctrl #(.REFRESH_CYCLES(REFRESH)) dut (
    .clk(clk), .rst(rst), .update(update), .digits(digits), .brightness(brightness),
    .display_on(display_on), .ready(ready), .done(done), .data_latch(data_latch),
    .data_byte(data_byte), .data_stop_bit(data_stop_bit), .drv_busy(drv_busy)
  );

  typedef struct {
    logic [7:0] b;
    logic       s;
  } exp_t;

  typedef struct {
    logic [31:0] digits;
    logic [2:0]  bright;
    logic        on;
    int          busy;
    logic [31:0] exp_raw;
    logic [31:0] exp_hex;
    logic [7:0]  ctrl;
  } vec_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int latch_cnt = 0;
  int done_cnt = 0;
  int busy_len = 2;
  int busy_rem = 0;
  logic done_prev = 1'b0;
  logic [7:0] held_byte = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] model_digit(input logic [7:0] d);
`ifdef TM1637_HEX_DECODE_EN
    logic [6:0] p;
    case (d[3:0])
      4'h0: p = 7'h3F; 4'h1: p = 7'h06; 4'h2: p = 7'h5B; 4'h3: p = 7'h4F;
      4'h4: p = 7'h66; 4'h5: p = 7'h6D; 4'h6: p = 7'h7D; 4'h7: p = 7'h07;
      4'h8: p = 7'h7F; 4'h9: p = 7'h6F; 4'hA: p = 7'h77; 4'hB: p = 7'h7C;
      4'hC: p = 7'h39; 4'hD: p = 7'h5E; 4'hE: p = 7'h79; default: p = 7'h71;
    endcase
    return {d[7], p};
`else
    return d;
`endif
  endfunction

  task automatic push_bytes(input logic [31:0] ed, input logic [7:0] ctrl);
    exp_q.push_back('{b: 8'h40, s: 1'b1});
    exp_q.push_back('{b: 8'hC0, s: 1'b0});
    exp_q.push_back('{b: ed[7:0], s: 1'b0});
    exp_q.push_back('{b: ed[15:8], s: 1'b0});
    exp_q.push_back('{b: ed[23:16], s: 1'b0});
    exp_q.push_back('{b: ed[31:24], s: 1'b1});
    exp_q.push_back('{b: ctrl, s: 1'b1});
  endtask

  task automatic push_frame(input logic [31:0] d, input logic [2:0] br, input logic on);
    push_bytes({model_digit(d[31:24]), model_digit(d[23:16]), model_digit(d[15:8]),
                model_digit(d[7:0])}, {4'b1000, on, br});
  endtask

  // byte-driver model and output monitor share one block so drv_busy is read before it is updated
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      if (drv_busy) check("byte_stable", data_byte, held_byte);
      if (data_latch) begin
        latch_cnt++;
        held_byte = data_byte;
        check("latch_while_busy", drv_busy, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_latch: got byte %0h, expected no latch", data_byte);
        end else begin
          e = exp_q.pop_front();
          check("data_byte", data_byte, e.b);
          check("stop_bit", data_stop_bit, e.s);
        end
        busy_rem = busy_len;
      end
      if (done) begin
        done_cnt++;
        check("done_width", done_prev, 1'b0);
      end
      done_prev = done;
    end else begin
      busy_rem  = 0;
      done_prev = 1'b0;
    end
    drv_busy = (busy_rem != 0);
    if (busy_rem != 0) busy_rem--;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_update();
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit, input string name);
    int n = 0;
    while (done_cnt < target && n < limit) begin
      tick();
      n++;
    end
    check(name, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_latch(input int target, input int limit, input string name);
    int n = 0;
    while (latch_cnt < target && n < limit) begin
      tick();
      n++;
    end
    check(name, 32'(latch_cnt >= target), 32'd1);
  endtask

  task automatic wait_done_cycle(input int limit, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!done && n < limit);
    check(name, done, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_latch"}, data_latch, 1'b0);
    check({tag, "_byte"}, data_byte, 8'h00);
    check({tag, "_stop"}, data_stop_bit, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_ready"}, ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int base_l, base_d, idle;
    vecs[0] = '{32'h664F5B06, 3'd7, 1'b1, 2, 32'h664F5B06, 32'h7D717C7D, 8'h8F};
    vecs[1] = '{32'h84030201, 3'd5, 1'b1, 3, 32'h84030201, 32'hE64F5B06, 8'h8D};
    vecs[2] = '{32'hFF00A5C3, 3'd0, 1'b0, 5, 32'hFF00A5C3, 32'hF13FEDCF, 8'h80};
    vecs[3] = '{32'h12345678, 3'd3, 1'b1, 2, 32'h12345678, 32'h5B667D7F, 8'h8B};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      digits     = vecs[i].digits;
      brightness = vecs[i].bright;
      display_on = vecs[i].on;
      busy_len   = vecs[i].busy;
      check("vec_ready_before", ready, 1'b1);
`ifdef TM1637_HEX_DECODE_EN
      push_bytes(vecs[i].exp_hex, vecs[i].ctrl);
`else
      push_bytes(vecs[i].exp_raw, vecs[i].ctrl);
`endif
      base_d = done_cnt;
      pulse_update();
      check("vec_ready_busy", ready, 1'b0);
      wait_done(base_d + 1, 400, "vec_done_timeout");
      check("vec_ready_after", ready, 1'b1);
      check("vec_queue_empty", exp_q.size(), 0);
    end

    // long driver busy: only the first byte may be latched while busy stays high
    busy_len = 500;
    digits = 32'h0A0B0C0D; brightness = 3'd2; display_on = 1'b1;
    push_frame(digits, brightness, display_on);
    base_l = latch_cnt;
    base_d = done_cnt;
    pulse_update();
    wait_latch(base_l + 1, 50, "slow_first_latch");
    repeat (450) tick();
    check("slow_single_latch", latch_cnt - base_l, 1);
    wait_done(base_d + 1, 5000, "slow_done_timeout");
    check("slow_queue_empty", exp_q.size(), 0);
    busy_len = 2;

    // three requests during a frame coalesce into one frame with digits taken at DONE
    digits = 32'h11111111; brightness = 3'd4; display_on = 1'b1;
    push_frame(digits, brightness, display_on);
    base_l = latch_cnt;
    base_d = done_cnt;
    pulse_update();
    wait_latch(base_l + 1, 50, "coal_first_latch");
    check("coal_not_ready", ready, 1'b0);
    digits = 32'h22222222;
    pulse_update();
    repeat (3) tick();
    pulse_update();
    digits = 32'h33333333;
    pulse_update();
    push_frame(digits, brightness, display_on);
    wait_latch(base_l + 8, 300, "coal_second_frame");
    digits = 32'hDEADBEEF;
    wait_done(base_d + 2, 400, "coal_done_timeout");
    repeat (20) tick();
    check("coal_latches", latch_cnt - base_l, 14);
    check("coal_dones", done_cnt - base_d, 2);
    check("coal_queue_empty", exp_q.size(), 0);

    // update in the DONE cycle itself restarts straight away
    digits = 32'h05060708; brightness = 3'd6; display_on = 1'b0;
    push_frame(digits, brightness, display_on);
    base_d = done_cnt;
    pulse_update();
    wait_done_cycle(400, "same_cycle_done_seen");
    update = 1'b1;
    digits = 32'h090A0B0C;
    push_frame(digits, brightness, display_on);
    @(posedge clk);
    #1;
    update = 1'b0;
    check("same_cycle_restart", ready, 1'b0);
    wait_done(base_d + 2, 400, "same_cycle_done_timeout");
    check("same_cycle_queue_empty", exp_q.size(), 0);

    // reset during the third byte abandons the frame
    digits = 32'h01020304; brightness = 3'd1; display_on = 1'b1;
    push_frame(digits, brightness, display_on);
    base_l = latch_cnt;
    pulse_update();
    wait_latch(base_l + 3, 200, "rst_mid_latch");
    rst = 1'b0;
    tick();
    check_reset_outputs("mid_reset");
    exp_q.delete();
    tick();
    rst = 1'b1;
    base_l = latch_cnt;
    repeat (30) tick();
    check("no_latch_after_reset", latch_cnt - base_l, 0);
    push_frame(digits, brightness, display_on);
    base_d = done_cnt;
    pulse_update();
    wait_done(base_d + 1, 400, "post_reset_done_timeout");
    check("post_reset_queue_empty", exp_q.size(), 0);

    // auto-refresh: a frame starts after REFRESH idle cycles
    digits = 32'h4F5B0666; brightness = 3'd1; display_on = 1'b1;
    push_frame(digits, brightness, display_on);
    base_d = done_cnt;
    pulse_update();
    wait_done_cycle(400, "refresh_prev_done");
    @(posedge clk);
    #1;
    push_frame(digits, brightness, display_on);
    idle = 0;
    while (ready && idle < 300) begin
      idle++;
      tick();
    end
    check("refresh_idle_cycles", idle, REFRESH);
    wait_done(base_d + 2, 400, "refresh_done_timeout");
    check("refresh_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tm1637_display_ctrl.md
TM1637_DISPLAY_CTRL -- requirements
Module: tm1637_display_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_CYCLES, default 0: idle cycles after which a frame is resent automatically; 0 disables auto-refresh.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port update  input  1  one-cycle request to send a full frame.
REQ-005 SHALL have port digits  input  32  digit bytes; digit0 = digits[7:0] ... digit3 = digits[31:24].
REQ-006 SHALL have port brightness  input  3  display brightness level 0-7.
REQ-007 SHALL have port display_on  input  1  display enable bit.
REQ-008 SHALL have port ready  output  1  high when idle and no request is pending.
REQ-009 SHALL have port done  output  1  one-cycle pulse on frame completion.
REQ-010 SHALL have port data_latch  output  1  one-cycle strobe to the byte driver.
REQ-011 SHALL have port data_byte  output  8  byte for the driver; held stable from strobe until the driver finishes.
REQ-012 SHALL have port data_stop_bit  output  1  driver emits STOP after this byte.
REQ-013 SHALL have port drv_busy  input  1  byte driver busy flag.

Function
REQ-014 SHALL use states IDLE, LOAD, LATCH, WAIT_HI, WAIT_LO, NEXT, DONE.
REQ-015 SHALL, on update in IDLE, snapshot digits, brightness and display_on, then go to LOAD on the next cycle.
REQ-016 SHALL send frame bytes in this order, byte : stop: 0x40 : 1; 0xC0 : 0; digit0 : 0; digit1 : 0; digit2 : 0; digit3 : 1; {4'b1000, display_on, brightness} : 1.
REQ-017 SHALL, in LOAD, drive data_byte and data_stop_bit for the current index; in LATCH, assert data_latch for exactly one cycle.
REQ-018 SHALL wait in WAIT_HI until drv_busy = 1, then in WAIT_LO until drv_busy = 0; NEXT then increments the index (0-6).
REQ-019 SHALL go from NEXT to DONE after index 6, and to LOAD otherwise.
REQ-020 SHALL, in DONE, pulse done for one cycle and return to IDLE.
REQ-021 SHALL never assert data_latch while drv_busy = 1.
REQ-022 SHALL record update arriving outside IDLE in a single pending flag; several such requests coalesce into one.
REQ-023 SHALL, when pending is set in DONE, start a new frame immediately (DONE->LOAD) with a fresh snapshot, and clear pending.
REQ-024 SHALL treat update and DONE in the same cycle as pending.
REQ-025 SHALL drive ready = 1 only in IDLE with pending = 0.
REQ-026 SHALL, when REFRESH_CYCLES > 0, count idle cycles and self-trigger a frame from current inputs when the count reaches REFRESH_CYCLES; the counter clears on any frame start.
REQ-027 SHALL keep data_byte and data_stop_bit unchanged from LOAD until the next LOAD.

Reset
REQ-028 SHALL, while rst = 0 at a clock edge, force state IDLE, index 0, pending 0, refresh counter 0.
REQ-029 SHALL hold outputs at data_latch 0, data_byte 0x00, data_stop_bit 0, done 0, ready 1 while in reset.
REQ-030 SHALL abandon a frame if reset occurs mid-frame, with no further strobes; a frame starts only on a new request after reset.

Configuration
REQ-031 SHALL, when TM1637_HEX_DECODE_EN is defined, decode bits [3:0] of each digit byte to the standard segment pattern (0->0x3F, 1->0x06, ..., F->0x71) and pass bit 7 (DP/colon) to segment bit 7; bits [6:4] are ignored.
REQ-032 SHALL, when TM1637_HEX_DECODE_EN is undefined, send digit bytes raw as segment patterns.

Verification
REQ-033 SHALL verify: raw mode, digits=0x664F5B06, brightness=7, on=1, driver model busy 2 cycles after latch -> bytes 40/1, C0/0, 06/0, 5B/0, 4F/0, 66/1, 8F/1, then done pulse, ready=1.
REQ-034 SHALL verify: decode mode, digits=0x84030201 -> digit bytes 0x06, 0x5B, 0x4F, 0xE6.
REQ-035 SHALL verify: three update pulses during a frame -> exactly one extra frame, carrying digits sampled at the first frame's DONE.
REQ-036 SHALL verify: rst=0 during byte 3 -> outputs at reset values next cycle; no latch until the next update.
REQ-037 SHALL verify: drv_busy held high 500 cycles -> no second latch until it falls; order intact.
REQ-038 SHALL verify: REFRESH_CYCLES=100, no update -> a frame starts 100 idle cycles after the previous done.
